// File: rtl/bcd_scan_pkg.sv
// Shared constants and the seven-segment decoder for the BCD scan counter.
// Segment order is {g,f,e,d,c,b,a}, active-low.
package bcd_scan_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [7:0] AN_OFF    = 8'hFF;

  function automatic logic [6:0] seg7_dec(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One decade of the BCD counter: steps up or down when i_step is set and
// raises o_carry (carry when counting up, borrow when counting down) at the decade boundary.
module bcd_digit_cell (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_step,
  input  logic       i_up,
  input  logic       i_clr,
  output logic [3:0] o_digit,
  output logic       o_carry
);

  logic [3:0] r_digit;
  logic [3:0] w_digit_nxt;

  always_comb begin
    w_digit_nxt = r_digit;
    if (i_clr) begin
      w_digit_nxt = 4'd0;
    end else if (i_step) begin
      if (i_up) begin
        w_digit_nxt = (r_digit == 4'd9) ? 4'd0 : r_digit + 4'd1;
      end else begin
        w_digit_nxt = (r_digit == 4'd0) ? 4'd9 : r_digit - 4'd1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_digit <= 4'd0;
    end else begin
      r_digit <= w_digit_nxt;
    end
  end

  assign o_digit = r_digit;
  assign o_carry = i_step & (i_up ? (r_digit == 4'd9) : (r_digit == 4'd0));

endmodule

// File: rtl/bcd_scan_counter.sv
// Multi-digit BCD up/down counter with prescaler, wrap pulse, leading-zero blanking
// and a time-multiplexed seven-segment driver.
module bcd_scan_counter
  import bcd_scan_pkg::*;
#(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned SCAN_DIV = 100000,
  parameter bit          LZ_BLANK = 1'b1
) (
  input  logic                  bcd_scan_counter_clk,
  input  logic                  bcd_scan_counter_rst,
  input  logic                  bcd_scan_counter_en,
  input  logic                  bcd_scan_counter_sel,
  input  logic                  bcd_scan_counter_clr,
  output logic [4*DIGITS-1:0]   bcd_scan_counter_value,
  output logic                  bcd_scan_counter_wrap,
  output logic [6:0]            bcd_scan_counter_cc,
  output logic [7:0]            bcd_scan_counter_an
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam int unsigned SW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_MAX  = SW'(SCAN_DIV - 1);
  localparam logic [2:0]    IDX_MAX   = 3'(DIGITS - 1);

  logic [PW-1:0]        r_presc;
  logic [PW-1:0]        w_presc_nxt;
  logic                 w_tick;
  logic [DIGITS:0]      w_step;
  logic [4*DIGITS-1:0]  w_value;
  logic                 r_wrap;
  logic [SW-1:0]        r_scan_cnt;
  logic [2:0]           r_idx;
  logic                 w_scan_end;
  logic [3:0]           w_dig [8];
  logic [7:0]           w_blank;
  logic                 w_zero_hi;
  logic [6:0]           r_cc;
  logic [7:0]           r_an;

  // clr suppresses the tick so neither the count nor wrap can move in a clear cycle.
  assign w_tick = bcd_scan_counter_en & ~bcd_scan_counter_clr & (r_presc == PRESC_MAX);

  always_comb begin
    w_presc_nxt = r_presc;
    if (bcd_scan_counter_clr) begin
      w_presc_nxt = '0;
    end else if (bcd_scan_counter_en) begin
      w_presc_nxt = (r_presc == PRESC_MAX) ? '0 : r_presc + 1'b1;
    end
  end

  assign w_step[0] = w_tick;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_cell u_cell (
      .i_clk   (bcd_scan_counter_clk),
      .i_rst_n (bcd_scan_counter_rst),
      .i_step  (w_step[g]),
      .i_up    (bcd_scan_counter_sel),
      .i_clr   (bcd_scan_counter_clr),
      .o_digit (w_value[4*g +: 4]),
      .o_carry (w_step[g+1])
    );
  end

  for (genvar g = 0; g < 8; g++) begin : g_pad
    if (g < DIGITS) begin : g_real
      assign w_dig[g] = w_value[4*g +: 4];
    end else begin : g_zero
      assign w_dig[g] = 4'd0;
    end
  end

  // Walk from the top digit down so each digit knows whether everything above it is zero.
  always_comb begin
    w_zero_hi = 1'b1;
    w_blank   = '0;
    for (int k = 7; k >= 0; k--) begin
      w_zero_hi  = w_zero_hi & (w_dig[k] == 4'd0);
      w_blank[k] = LZ_BLANK && (k != 0) && w_zero_hi;
    end
  end

  assign w_scan_end = (r_scan_cnt == SCAN_MAX);

  always_ff @(posedge bcd_scan_counter_clk or negedge bcd_scan_counter_rst) begin
    if (!bcd_scan_counter_rst) begin
      r_presc    <= '0;
      r_wrap     <= 1'b0;
      r_scan_cnt <= '0;
      r_idx      <= 3'd0;
      r_cc       <= SEG_BLANK;
      r_an       <= AN_OFF;
    end else begin
      r_presc <= w_presc_nxt;
      r_wrap  <= w_step[DIGITS];
      if (w_scan_end) begin
        r_scan_cnt <= '0;
        r_idx      <= (r_idx == IDX_MAX) ? 3'd0 : r_idx + 3'd1;
      end else begin
        r_scan_cnt <= r_scan_cnt + 1'b1;
      end
      r_an <= ~(8'b1 << r_idx);
      r_cc <= w_blank[r_idx] ? SEG_BLANK : seg7_dec(w_dig[r_idx]);
    end
  end

  assign bcd_scan_counter_value = w_value;
  assign bcd_scan_counter_wrap  = r_wrap;
  assign bcd_scan_counter_cc    = r_cc;
  assign bcd_scan_counter_an    = r_an;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Scoreboard bench for bcd_scan_counter: expected count updates are queued by the stimulus
// and popped by a monitor each time the DUT's value changes or wrap pulses.
module tb_bcd_scan_counter;

  typedef struct {
    logic [15:0] v;
    logic        w;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        sel = 1'b1;
  logic        clr = 1'b0;
  logic [15:0] value;
  logic        wrap;
  logic [6:0]  cc;
  logic [7:0]  an;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;

  bcd_scan_counter #(
    .DIGITS   (4),
    .TICK_DIV (4),
    .SCAN_DIV (2),
    .LZ_BLANK (1'b1)
  ) dut (
    .bcd_scan_counter_clk   (clk),
    .bcd_scan_counter_rst   (rst_n),
    .bcd_scan_counter_en    (en),
    .bcd_scan_counter_sel   (sel),
    .bcd_scan_counter_clr   (clr),
    .bcd_scan_counter_value (value),
    .bcd_scan_counter_wrap  (wrap),
    .bcd_scan_counter_cc    (cc),
    .bcd_scan_counter_an    (an)
  );

  function automatic logic [15:0] to_bcd(input int n);
    logic [15:0] r;
    int m;
    m = n;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  function automatic void push(input logic [15:0] v, input logic w);
    exp_t e;
    e.v = v;
    e.w = w;
    exp_q.push_back(e);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Watch a full scan round with the count frozen; every digit must be lit with its pattern.
  task automatic check_display(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                               input logic [6:0] e2, input logic [6:0] e3);
    logic [6:0] exp_cc [4];
    logic [6:0] seen_cc [4];
    bit         seen [4];
    bit         found;
    exp_cc = '{e0, e1, e2, e3};
    seen   = '{0, 0, 0, 0};
    seen_cc = '{7'h0, 7'h0, 7'h0, 7'h0};
    repeat (2) @(posedge clk);
    for (int s = 0; s < 10; s++) begin
      @(negedge clk);
      found = 1'b0;
      for (int k = 0; k < 4; k++) begin
        if (an == ~(8'b1 << k)) begin
          seen[k]    = 1'b1;
          seen_cc[k] = cc;
          found      = 1'b1;
        end
      end
      n_vec++;
      if (!found) begin
        n_miss++;
        $display("FAIL %s an_onehot: got an=%h, expected one of FE/FD/FB/F7", tag, an);
      end
    end
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if (!seen[k] || seen_cc[k] !== exp_cc[k]) begin
        n_miss++;
        $display("FAIL %s digit%0d cc: got %h (seen=%0d), expected %h",
                 tag, k, seen_cc[k], seen[k], exp_cc[k]);
      end
    end
    step();
  endtask

  // Monitor: any value change or wrap pulse must match the next queued expectation.
  initial begin : monitor
    logic [15:0] prev;
    exp_t e;
    prev = 16'h0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = value;
      end else if (value !== prev || wrap !== 1'b0) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_miss++;
          $display("FAIL unexpected_update: got value=%h wrap=%b, expected no change from %h",
                   value, wrap, prev);
        end else begin
          e = exp_q.pop_front();
          if (value !== e.v || wrap !== e.w) begin
            n_miss++;
            $display("FAIL count_update: got value=%h wrap=%b, expected value=%h wrap=%b",
                     value, wrap, e.v, e.w);
          end
        end
        prev = value;
      end
    end
  end

  initial begin : stimulus
    int waited;

    // Reset state
    repeat (3) step();
    check("rst_value", 32'(value), 32'h0);
    check("rst_wrap", 32'(wrap), 32'h0);
    check("rst_an", 32'(an), 32'hFF);
    check("rst_cc", 32'(cc), 32'h7F);
    @(posedge clk);
    #2 rst_n = 1'b1;
    step();

    // 1: first tick lands TICK_DIV edges after en rises
    sel = 1'b1;
    en  = 1'b1;
    push(16'h0001, 1'b0);
    repeat (3) step();
    check("t1_no_early", 32'(value), 32'h0);
    step();
    check("t1_value", 32'(value), 32'h0001);
    en = 1'b0;
    check_display("t1", 7'h79, 7'h7F, 7'h7F, 7'h7F);

    // 2: count up through 9999 and wrap
    for (int n = 2; n <= 9999; n++) push(to_bcd(n), 1'b0);
    push(16'h0000, 1'b1);
    en = 1'b1;
    repeat (9999 * 4) step();
    en = 1'b0;
    check("t2_value", 32'(value), 32'h0);
    check("t2_wrap", 32'(wrap), 32'h1);
    step();
    check("t2_wrap_one_cycle", 32'(wrap), 32'h0);

    // 3: down from zero wraps to 9999
    sel = 1'b0;
    en  = 1'b1;
    push(16'h9999, 1'b1);
    repeat (4) step();
    en = 1'b0;
    check("t3_value", 32'(value), 32'h9999);
    check("t3_wrap", 32'(wrap), 32'h1);
    step();
    check("t3_wrap_one_cycle", 32'(wrap), 32'h0);
    check_display("t3", 7'h10, 7'h10, 7'h10, 7'h10);

    // 4: pause mid-prescale, then tick after the remaining count
    en = 1'b1;
    repeat (2) step();
    en = 1'b0;
    repeat (10) step();
    check("t4_hold", 32'(value), 32'h9999);
    en = 1'b1;
    push(16'h9998, 1'b0);
    step();
    check("t4_no_early", 32'(value), 32'h9999);
    step();
    check("t4_tick", 32'(value), 32'h9998);
    en = 1'b0;

    // 5: clear coincides with a tick
    sel = 1'b1;
    en  = 1'b1;
    push(16'h0000, 1'b0);
    push(16'h0001, 1'b0);
    repeat (3) step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("t5_clr_value", 32'(value), 32'h0);
    check("t5_clr_wrap", 32'(wrap), 32'h0);
    repeat (3) step();
    check("t5_presc_zero", 32'(value), 32'h0);
    step();
    check("t5_next_tick", 32'(value), 32'h0001);
    en = 1'b0;

    // 6: build 0120, check blanking, then async reset mid-scan
    for (int n = 2; n <= 120; n++) push(to_bcd(n), 1'b0);
    en = 1'b1;
    repeat (119 * 4) step();
    en = 1'b0;
    check("t6_value", 32'(value), 32'h0120);
    check_display("t6", 7'h40, 7'h24, 7'h79, 7'h7F);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_an", 32'(an), 32'hFF);
    check("t6_rst_cc", 32'(cc), 32'h7F);
    check("t6_rst_value", 32'(value), 32'h0);
    step();
    check("t6_rst_hold_an", 32'(an), 32'hFF);
    @(posedge clk);
    #2 rst_n = 1'b1;
    step();
    check("t6_scan_digit0", 32'(an), 32'hFE);
    repeat (2) step();
    check("t6_scan_digit1", 32'(an), 32'hFD);

    // Drain the scoreboard with a bounded wait
    waited = 0;
    while (exp_q.size() != 0 && waited < 20) begin
      step();
      waited++;
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL scoreboard_drain: got %0d pending updates, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
